// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the matrix keypad scanner.
// master = the scanner itself, slave = the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  key_col,
    output key_row,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output key_col,
    input  key_row,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row-by-row scan, frame-level
// debounce, one key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 25,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic              clk_10000Hz,
  input  logic              reset,
  keypad_scanner_if.master  bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] LastDwell   = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CountTarget = CW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_rowIdx;
  logic [3:0]    r_keyRow;

  logic          r_accFound;
  logic          r_accMulti;
  logic [3:0]    r_accKey;

  state_t        r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_count;
  logic [3:0]    r_keyCode;
  logic          r_keyValid;
  logic          r_keyHeld;

  logic          w_sample;
  logic          w_frameEnd;
  logic [1:0]    w_nextRow;
  logic          w_rowOne;
  logic          w_rowMulti;
  logic [1:0]    w_col;
  logic          w_frameFound;
  logic          w_frameMulti;
  logic [3:0]    w_frameKey;
  logic          w_single;
  logic          w_none;
  logic          w_anyKey;
  logic [CW-1:0] w_countNext;
  logic          w_countDone;

  assign w_sample   = (r_dwell == LastDwell);
  assign w_frameEnd = w_sample && (r_rowIdx == 2'd3);
  assign w_nextRow  = r_rowIdx + 2'd1;

  // Synchronizer and row scan; key_row is registered alongside row_idx.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 4'b1111;
      r_sync2  <= 4'b1111;
      r_dwell  <= '0;
      r_rowIdx <= 2'd0;
      r_keyRow <= 4'b1110;
    end else begin
      r_sync1 <= bus.key_col;
      r_sync2 <= r_sync1;
      if (w_sample) begin
        r_dwell  <= '0;
        r_rowIdx <= w_nextRow;
        r_keyRow <= ~(4'b0001 << w_nextRow);
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  always_comb begin
    w_rowOne   = 1'b0;
    w_rowMulti = 1'b0;
    w_col      = 2'd0;
    case (~r_sync2)
      4'b0000: w_rowOne = 1'b0;
      4'b0001: begin w_rowOne = 1'b1; w_col = 2'd0; end
      4'b0010: begin w_rowOne = 1'b1; w_col = 2'd1; end
      4'b0100: begin w_rowOne = 1'b1; w_col = 2'd2; end
      4'b1000: begin w_rowOne = 1'b1; w_col = 2'd3; end
      default: w_rowMulti = 1'b1;
    endcase
  end

  // A key in a second row makes the whole frame MULTI.
  assign w_frameFound = r_accFound | w_rowOne;
  assign w_frameMulti = r_accMulti | w_rowMulti | (r_accFound & w_rowOne);
  assign w_frameKey   = w_rowOne ? {r_rowIdx, w_col} : r_accKey;

  assign w_single = w_frameEnd & w_frameFound & ~w_frameMulti;
  assign w_none   = w_frameEnd & ~w_frameFound & ~w_frameMulti;
  assign w_anyKey = w_frameEnd & (w_frameFound | w_frameMulti);

  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      r_accFound <= 1'b0;
      r_accMulti <= 1'b0;
      r_accKey   <= 4'd0;
    end else if (w_frameEnd) begin
      r_accFound <= 1'b0;
      r_accMulti <= 1'b0;
      r_accKey   <= 4'd0;
    end else if (w_sample) begin
      r_accFound <= w_frameFound;
      r_accMulti <= w_frameMulti;
      r_accKey   <= w_frameKey;
    end
  end

  assign w_countNext = r_count + CW'(1);
  assign w_countDone = (w_countNext == CountTarget);

  // Debounce FSM, stepped only at frame end; all outputs registered.
  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cand     <= 4'd0;
      r_count    <= '0;
      r_keyCode  <= 4'd0;
      r_keyValid <= 1'b0;
      r_keyHeld  <= 1'b0;
    end else begin
      r_keyValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_single) begin
            r_cand <= w_frameKey;
            if (DEBOUNCE_FRAMES == 1) begin
              r_state    <= PRESSED;
              r_count    <= '0;
              r_keyCode  <= w_frameKey;
              r_keyValid <= 1'b1;
              r_keyHeld  <= 1'b1;
            end else begin
              r_state <= DEBOUNCE;
              r_count <= CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (w_single && (w_frameKey == r_cand)) begin
            if (w_countDone) begin
              r_state    <= PRESSED;
              r_count    <= '0;
              r_keyCode  <= r_cand;
              r_keyValid <= 1'b1;
              r_keyHeld  <= 1'b1;
            end else begin
              r_count <= w_countNext;
            end
          end else if (w_single) begin
            r_cand  <= w_frameKey;
            r_count <= CW'(1);
          end else if (w_frameEnd) begin
            r_state <= IDLE;
            r_count <= '0;
          end
        end
        PRESSED: begin
          if (w_none) begin
            if (DEBOUNCE_FRAMES == 1) begin
              r_state   <= IDLE;
              r_count   <= '0;
              r_keyHeld <= 1'b0;
            end else begin
              r_state <= RELEASE;
              r_count <= CW'(1);
            end
          end
        end
        RELEASE: begin
          if (w_none) begin
            if (w_countDone) begin
              r_state   <= IDLE;
              r_count   <= '0;
              r_keyHeld <= 1'b0;
            end else begin
              r_count <= w_countNext;
            end
          end else if (w_anyKey) begin
            r_state <= PRESSED;
            r_count <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign bus.key_row   = r_keyRow;
  assign bus.key_code  = r_keyCode;
  assign bus.key_valid = r_keyValid;
  assign bus.key_held  = r_keyHeld;

endmodule
